// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter (instruction fetch / data stage) onto one shared memory port.
// Define ARB_STARVE_GUARD_EN to bound how many data grants may pass a waiting fetch.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned STARVE_MAX = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [7:0]        if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_done,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_done,
  output logic              stall_if,
  output logic              stall_dm,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
);

  typedef enum logic [1:0] {
    StIdle,
    StGntIf,
    StGntDm
  } state_e;

  state_e              state_q;
  logic                arm_q;
  logic                mem_req_q;
  logic                mem_we_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [DATA_W-1:0]   mem_wdata_q;
  logic [DATA_W-1:0]   if_rdata_q;
  logic [DATA_W-1:0]   dm_rdata_q;
  logic                if_done_q;
  logic                dm_done_q;
`ifdef ARB_STARVE_GUARD_EN
  logic [3:0]          starve_q;
`endif

  logic arb_ok;
  logic pick_dm;
  logic pick_if;

  // Arbitration happens in IDLE (once armed) and on every ack edge, so grants chain
  // back-to-back without an IDLE bubble.
  always_comb begin
    arb_ok  = (state_q == StIdle) ? arm_q : mem_ack;
    pick_dm = dm_req;
    pick_if = if_req & ~dm_req;
`ifdef ARB_STARVE_GUARD_EN
    if (if_req && dm_req && (starve_q == 4'(STARVE_MAX))) begin
      pick_dm = 1'b0;
      pick_if = 1'b1;
    end
`endif
  end

  // arm_q holds off arbitration for the first edge after reset release.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      arm_q       <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      if_done_q   <= 1'b0;
      dm_done_q   <= 1'b0;
`ifdef ARB_STARVE_GUARD_EN
      starve_q    <= '0;
`endif
    end else begin
      arm_q     <= 1'b1;
      if_done_q <= 1'b0;
      dm_done_q <= 1'b0;

      if ((state_q == StGntIf) && mem_ack) begin
        if_rdata_q <= mem_rdata;
        if_done_q  <= 1'b1;
      end
      if ((state_q == StGntDm) && mem_ack) begin
        if (!mem_we_q) begin
          dm_rdata_q <= mem_rdata;
        end
        dm_done_q <= 1'b1;
      end

      if (arb_ok) begin
        if (pick_dm) begin
          state_q     <= StGntDm;
          mem_req_q   <= 1'b1;
          mem_we_q    <= dm_we;
          mem_addr_q  <= dm_addr;
          mem_wdata_q <= dm_wdata;
`ifdef ARB_STARVE_GUARD_EN
          if (if_req && (starve_q != 4'hF)) begin
            starve_q <= starve_q + 4'd1;
          end
`endif
        end else if (pick_if) begin
          state_q    <= StGntIf;
          mem_req_q  <= 1'b1;
          mem_we_q   <= 1'b0;
          mem_addr_q <= ADDR_W'(if_addr);
`ifdef ARB_STARVE_GUARD_EN
          starve_q   <= '0;
`endif
        end else begin
          state_q   <= StIdle;
          mem_req_q <= 1'b0;
          mem_we_q  <= 1'b0;
        end
      end
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;
  assign if_done   = if_done_q;
  assign dm_done   = dm_done_q;
  assign stall_if  = if_req & ~if_done_q;
  assign stall_dm  = dm_req & ~dm_done_q;

endmodule
